operand_b_loader: RTL and testbench
===================================

Name: operand_b_loader

Overview:
- Initiator-side sequencer for the B operand register of the systolic matrix multiplier.
- Accepts a B matrix row by row over a valid/ready stream and drives the register's row-write port (write enable, row address, data, byte strobes).
- Zero-fills rows beyond the active dimension.
- Then drives start_bit and the skew counter sequence that makes the register emit its diagonal operand buffer, and signals completion.

Parameters:
- BUS_WIDTH, 16, width of one matrix row word.
- DATA_WIDTH, 8, width of one element.
- Derived (localparams): MAX_DIM = BUS_WIDTH/DATA_WIDTH; AW = $clog2(MAX_DIM); CW = $clog2(3*MAX_DIM-2); LAST = 3*MAX_DIM-3.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- go_i  in  1  request to load and stream one matrix; sampled only in IDLE.
- k_i  in  2  highest valid row index of B; latched on go.
- m_i  in  2  highest valid column index of B; latched on go.
- row_valid_i  in  1  row word available.
- row_data_i  in  BUS_WIDTH  row word; element c in bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH].
- row_ready_o  out  1  loader accepts a row this cycle.
- write_en_Mat_o  out  1  row write strobe to the operand register.
- addr_Mat_o  out  AW  row address.
- pwdata_o  out  BUS_WIDTH  row write data.
- pstrb_o  out  MAX_DIM  element strobes.
- start_bit_o  out  1  operand buffer streaming enable.
- counter_o  out  CW  skew counter.
- reload_op_o  out  1  one-cycle pulse at end of stream.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous: FSM to IDLE. All outputs 0, all internal counters 0, latched k/m cleared. Takes effect immediately, including mid-LOAD or mid-STREAM. No partial writes or further strobes after reset asserts.
- All outputs are registered.
- States: IDLE, LOAD, CLEAR, STREAM, DONE.
- IDLE:
  - row_ready_o = 0.
  - On go_i: latch kq = min(k_i, MAX_DIM-1) and mq = min(m_i, MAX_DIM-1); row_idx = 0; go to LOAD.
- LOAD:
  - row_ready_o = 1 while row_idx <= kq.
  - Handshake: row_valid_i && row_ready_o.
  - Next cycle after a handshake: write_en_Mat_o = 1 for exactly one cycle, with:
    - addr_Mat_o = row_idx;
    - pwdata_o = row_data_i with every element c > mq forced to 0;
    - pstrb_o = all ones.
  - row_idx then increments.
  - row_ready_o deasserts in the cycle after the handshake of row kq.
  - No handshake means no write; gaps in row_valid_i are arbitrary.
  - After row kq is accepted:
    - if kq < MAX_DIM-1, go to CLEAR with row_idx = kq+1;
    - otherwise go to STREAM.
- CLEAR:
  - One write per cycle: addr_Mat_o = row_idx, pwdata_o = 0, pstrb_o = all ones. Rows kq+1 .. MAX_DIM-1 in order.
  - row_ready_o = 0.
  - After the last row, go to STREAM.
- STREAM:
  - start_bit_o = 1; write_en_Mat_o = 0.
  - counter_o = 0 on the first STREAM cycle, +1 per cycle, up to LAST. That is 3*MAX_DIM-2 cycles total, no wrap.
  - After counter_o = LAST, go to DONE.
- DONE, one cycle:
  - start_bit_o = 0, counter_o = 0.
  - done_o = 1 and reload_op_o = 1, both for this cycle only.
  - Go to IDLE.
- go_i outside IDLE is ignored and not queued.
- k_i/m_i changes after latch have no effect on the current matrix.
- write_en_Mat_o and start_bit_o are never high in the same cycle.
- busy_o is 1 from the cycle after go through DONE inclusive.
- Output defaults: write_en_Mat_o, pwdata_o, pstrb_o and addr_Mat_o are 0 whenever no write is issued.

Test Plan (defaults, MAX_DIM=2, LAST=3):
- Full matrix: go with k=1, m=1; rows 0x0201 then 0x0403 back-to-back -> writes (addr0, 0x0201, pstrb 11), then (addr1, 0x0403, 11); no CLEAR; counter_o 0,1,2,3 with start_bit_o=1; then done_o and reload_op_o one cycle each; busy_o drops.
- Reduced dims: k=0, m=0; row 0xABCD -> write (addr0, 0x00CD), then CLEAR write (addr1, 0x0000); stream 0..3; done.
- Backpressure/gaps: k=1; row_valid_i low 3 cycles between rows -> exactly two writes, each one cycle after its handshake; no spurious write_en_Mat_o.
- Clamp and ignore: k_i=3 -> only 2 rows accepted (row_ready_o low after 2nd). go_i pulsed during STREAM -> no restart, done_o exactly once.
- Reset mid-stream: assert rst_i while counter_o=2 -> start_bit_o, counter_o, busy_o go 0 asynchronously; no done_o. After release, a new go runs a full normal sequence.
- Reset mid-load: assert rst_i between row handshakes -> row_ready_o and write_en_Mat_o 0 immediately; FSM in IDLE.

Source files
------------

// File: rtl/operand_b_loader.sv
// operand_b_loader
//   Initiator-side sequencer for the B operand register of the systolic
//   matrix multiplier. It takes a B matrix row by row over a valid/ready
//   stream and writes each row into the register. Columns beyond the active
//   width are zeroed, and rows beyond the active height are written as zero.
//   It then drives start_bit/counter through the skew sequence that makes
//   the register emit its diagonal operand buffer. Completion is signalled
//   by done/reload pulses.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   go_i              start request (IDLE only); k_i/m_i latched with it
//   k_i, m_i          highest valid row / column index of B
//   row_valid_i       row word available
//   row_data_i        row word; element c at [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH]
//   row_ready_o       loader accepts a row this cycle
//   write_en_Mat_o    row write strobe
//   addr_Mat_o        row write address
//   pwdata_o          row write data
//   pstrb_o           row write element strobes
//   start_bit_o       operand buffer streaming enable
//   counter_o         skew counter
//   reload_op_o       end-of-stream pulse
//   busy_o            not idle
//   done_o            completion pulse
module operand_b_loader #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   go_i,
  input  logic [1:0]                             k_i,
  input  logic [1:0]                             m_i,
  input  logic                                   row_valid_i,
  input  logic [BUS_WIDTH-1:0]                   row_data_i,
  output logic                                   row_ready_o,
  output logic                                   write_en_Mat_o,
  output logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0] addr_Mat_o,
  output logic [BUS_WIDTH-1:0]                   pwdata_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0]        pstrb_o,
  output logic                                   start_bit_o,
  output logic [$clog2(3*(BUS_WIDTH/DATA_WIDTH)-2)-1:0] counter_o,
  output logic                                   reload_op_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int AW      = $clog2(MAX_DIM);
  localparam int CW      = $clog2(3 * MAX_DIM - 2);
  localparam int LAST    = 3 * MAX_DIM - 3;

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          kq_q, kq_d;
  logic [AW-1:0]          mq_q, mq_d;
  logic [AW-1:0]          row_idx_q, row_idx_d;
  logic                   row_ready_q, row_ready_d;
  logic                   wr_q, wr_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [BUS_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [MAX_DIM-1:0]     pstrb_q, pstrb_d;
  logic                   start_bit_q, start_bit_d;
  logic [CW-1:0]          counter_q, counter_d;
  logic                   reload_q, reload_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      kq_q        <= '0;
      mq_q        <= '0;
      row_idx_q   <= '0;
      row_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      start_bit_q <= 1'b0;
      counter_q   <= '0;
      reload_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kq_q        <= kq_d;
      mq_q        <= mq_d;
      row_idx_q   <= row_idx_d;
      row_ready_q <= row_ready_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      start_bit_q <= start_bit_d;
      counter_q   <= counter_d;
      reload_q    <= reload_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Outputs are registered, so the state register runs one step ahead of
  // what is visible. Entering STREAM therefore spends one cycle showing the
  // final row write before start_bit rises. This keeps write_en and
  // start_bit from ever overlapping.
  always_comb begin
    state_d     = state_q;
    kq_d        = kq_q;
    mq_d        = mq_q;
    row_idx_d   = row_idx_q;
    row_ready_d = 1'b0;
    wr_d        = 1'b0;
    addr_d      = '0;
    pwdata_d    = '0;
    pstrb_d     = '0;
    start_bit_d = 1'b0;
    counter_d   = '0;
    reload_d    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (go_i) begin
          kq_d        = (32'(k_i) > MAX_DIM - 1) ? AW'(MAX_DIM - 1) : AW'(k_i);
          mq_d        = (32'(m_i) > MAX_DIM - 1) ? AW'(MAX_DIM - 1) : AW'(m_i);
          row_idx_d   = '0;
          row_ready_d = 1'b1;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        row_ready_d = 1'b1;
        if (row_valid_i && row_ready_q) begin
          wr_d    = 1'b1;
          addr_d  = row_idx_q;
          pstrb_d = '1;
          for (int unsigned c = 0; c < MAX_DIM; c++) begin
            if (c <= 32'(mq_q)) begin
              pwdata_d[c*DATA_WIDTH +: DATA_WIDTH] = row_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (row_idx_q == kq_q) begin
            row_ready_d = 1'b0;
            if (kq_q != AW'(MAX_DIM - 1)) begin
              row_idx_d = kq_q + 1'b1;
              state_d   = CLEAR;
            end else begin
              state_d   = STREAM;
            end
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end

      CLEAR: begin
        wr_d    = 1'b1;
        addr_d  = row_idx_q;
        pstrb_d = '1;
        if (row_idx_q == AW'(MAX_DIM - 1)) begin
          state_d = STREAM;
        end else begin
          row_idx_d = row_idx_q + 1'b1;
        end
      end

      STREAM: begin
        if (!start_bit_q) begin
          start_bit_d = 1'b1;
          counter_d   = '0;
        end else if (counter_q == CW'(LAST)) begin
          done_d   = 1'b1;
          reload_d = 1'b1;
          state_d  = DONE;
        end else begin
          start_bit_d = 1'b1;
          counter_d   = counter_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign row_ready_o    = row_ready_q;
  assign write_en_Mat_o = wr_q;
  assign addr_Mat_o     = addr_q;
  assign pwdata_o       = pwdata_q;
  assign pstrb_o        = pstrb_q;
  assign start_bit_o    = start_bit_q;
  assign counter_o      = counter_q;
  assign reload_op_o    = reload_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_operand_b_loader.sv
module tb_operand_b_loader;

  localparam int BUS_WIDTH  = 16;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int AW         = $clog2(MAX_DIM);
  localparam int CW         = $clog2(3 * MAX_DIM - 2);
  localparam int LAST       = 3 * MAX_DIM - 3;

  logic                 clk, rst_i, go_i, row_valid_i;
  logic [1:0]           k_i, m_i;
  logic [BUS_WIDTH-1:0] row_data_i;
  logic                 row_ready_o, write_en_Mat_o, start_bit_o;
  logic                 reload_op_o, busy_o, done_o;
  logic [AW-1:0]        addr_Mat_o;
  logic [BUS_WIDTH-1:0] pwdata_o;
  logic [MAX_DIM-1:0]   pstrb_o;
  logic [CW-1:0]        counter_o;

  operand_b_loader #(.BUS_WIDTH(BUS_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .go_i(go_i), .k_i(k_i), .m_i(m_i),
    .row_valid_i(row_valid_i), .row_data_i(row_data_i), .row_ready_o(row_ready_o),
    .write_en_Mat_o(write_en_Mat_o), .addr_Mat_o(addr_Mat_o), .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o), .start_bit_o(start_bit_o), .counter_o(counter_o),
    .reload_op_o(reload_op_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done_cnt = 0;

  // Scoreboard of expected writes: {addr, data, strobes}
  typedef struct packed {
    logic [AW-1:0]        addr;
    logic [BUS_WIDTH-1:0] data;
    logic [MAX_DIM-1:0]   strb;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every issued write must match the next scoreboard entry.
  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst_i && write_en_Mat_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(write_en_Mat_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(addr_Mat_o), 32'(e.addr));
        check("write_data", 32'(pwdata_o), 32'(e.data));
        check("write_strb", 32'(pstrb_o), 32'(e.strb));
      end
      check("write_vs_start_bit", 32'(start_bit_o), 32'd0);
    end
    if (done_o) done_cnt++;
  end

  task automatic do_go(input logic [1:0] k, input logic [1:0] m);
    @(negedge clk);
    go_i = 1'b1; k_i = k; m_i = m;
    @(negedge clk);
    go_i = 1'b0;
    check("busy_after_go", 32'(busy_o), 32'd1);
    check("ready_after_go", 32'(row_ready_o), 32'd1);
  endtask

  // Presents a row until accepted; expects the write on the following cycle.
  task automatic send_row(input logic [BUS_WIDTH-1:0] data,
                          input logic [BUS_WIDTH-1:0] exp_data,
                          input logic [AW-1:0] addr);
    bit ok = 0;
    wr_t e;
    row_data_i  = data;
    row_valid_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (row_ready_o) begin
        e.addr = addr; e.data = exp_data; e.strb = '1;
        exp_q.push_back(e);
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("row_accept_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    row_valid_i = 1'b0;
    check("write_one_cycle_after_hs", 32'(write_en_Mat_o), 32'd1);
  endtask

  task automatic run_stream(input bit pulse_go);
    int d0;
    for (int n = 0; n < 4; n++) begin
      if (start_bit_o) break;
      @(negedge clk);
    end
    check("stream_started", 32'(start_bit_o), 32'd1);
    d0 = done_cnt;
    for (int i = 0; i <= LAST; i++) begin
      check("stream_counter", 32'(counter_o), 32'(i));
      check("stream_start_bit", 32'(start_bit_o), 32'd1);
      check("stream_no_write", 32'(write_en_Mat_o), 32'd0);
      if (pulse_go && i == 1) go_i = 1'b1;
      if (i == 2) go_i = 1'b0;
      @(negedge clk);
    end
    check("done_pulse", 32'(done_o), 32'd1);
    check("reload_pulse", 32'(reload_op_o), 32'd1);
    check("done_start_bit_low", 32'(start_bit_o), 32'd0);
    check("done_counter_zero", 32'(counter_o), 32'd0);
    check("done_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("reload_one_cycle", 32'(reload_op_o), 32'd0);
    check("busy_dropped", 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("no_restart_busy", 32'(busy_o), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    wr_t e;
    rst_i = 1'b1; go_i = 1'b0; k_i = '0; m_i = '0;
    row_valid_i = 1'b0; row_data_i = '0;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(row_ready_o), 32'd0);
    check("rst_wr", 32'(write_en_Mat_o), 32'd0);
    check("rst_start", 32'(start_bit_o), 32'd0);
    check("rst_counter", 32'(counter_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_reload", 32'(reload_op_o), 32'd0);
    check("rst_addr", 32'(addr_Mat_o), 32'd0);
    check("rst_pwdata", 32'(pwdata_o), 32'd0);
    check("rst_pstrb", 32'(pstrb_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_ready_low", 32'(row_ready_o), 32'd0);

    // Full matrix, back-to-back rows
    do_go(2'd1, 2'd1);
    send_row(16'h0201, 16'h0201, 1'b0);
    send_row(16'h0403, 16'h0403, 1'b1);
    check("full_ready_low", 32'(row_ready_o), 32'd0);
    run_stream(1'b0);

    // Reduced dims: column mask and CLEAR of row 1
    do_go(2'd0, 2'd0);
    send_row(16'hABCD, 16'h00CD, 1'b0);
    e.addr = 1'b1; e.data = '0; e.strb = '1;
    exp_q.push_back(e);
    @(negedge clk);
    check("clear_write", 32'(write_en_Mat_o), 32'd1);
    check("clear_ready_low", 32'(row_ready_o), 32'd0);
    run_stream(1'b0);

    // Gaps in row_valid
    do_go(2'd1, 2'd1);
    send_row(16'h5566, 16'h5566, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_no_write", 32'(write_en_Mat_o), 32'd0);
      check("gap_ready", 32'(row_ready_o), 32'd1);
    end
    send_row(16'h7788, 16'h7788, 1'b1);
    run_stream(1'b0);

    // Clamp k/m, later k/m changes ignored, go during STREAM ignored
    do_go(2'd3, 2'd3);
    k_i = 2'd0; m_i = 2'd0;
    send_row(16'h1111, 16'h1111, 1'b0);
    send_row(16'h2222, 16'h2222, 1'b1);
    check("clamp_ready_low", 32'(row_ready_o), 32'd0);
    row_data_i = 16'h3333; row_valid_i = 1'b1;
    run_stream(1'b1);
    row_valid_i = 1'b0;

    // Reset mid-stream
    do_go(2'd1, 2'd1);
    send_row(16'h0A0B, 16'h0A0B, 1'b0);
    send_row(16'h0C0D, 16'h0C0D, 1'b1);
    for (int n = 0; n < 10; n++) begin
      if (start_bit_o && counter_o == CW'(2)) break;
      @(negedge clk);
    end
    check("mid_stream_counter2", 32'(counter_o), 32'd2);
    #1 rst_i = 1'b1;
    #1;
    check("rs_start_bit", 32'(start_bit_o), 32'd0);
    check("rs_counter", 32'(counter_o), 32'd0);
    check("rs_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rs_no_done", 32'(done_o), 32'd0);
    end
    rst_i = 1'b0;
    do_go(2'd1, 2'd1);
    send_row(16'h1234, 16'h1234, 1'b0);
    send_row(16'h5678, 16'h5678, 1'b1);
    run_stream(1'b0);

    // Reset mid-load, right as row 0's write is visible
    do_go(2'd1, 2'd1);
    send_row(16'h99AA, 16'h99AA, 1'b0);
    #1 rst_i = 1'b1;
    #1;
    check("rl_wr", 32'(write_en_Mat_o), 32'd0);
    check("rl_ready", 32'(row_ready_o), 32'd0);
    check("rl_busy", 32'(busy_o), 32'd0);
    check("rl_pwdata", 32'(pwdata_o), 32'd0);
    row_data_i = 16'hBEEF; row_valid_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rl_idle_ready", 32'(row_ready_o), 32'd0);
      check("rl_idle_busy", 32'(busy_o), 32'd0);
    end
    row_valid_i = 1'b0;
    check("rl_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
